alu: RTL and testbench

//   32-bit integer ALU for the CPU execute stage. Shifts/selects operand 2
//   (barrel shifter or 16-bit immediate) and performs one of 16

---
 rtl/alu.sv | 128 ++++++++++++
 tb/tb_alu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit execute-stage ALU: operand-2 shifter/immediate select, 16 ops,
// NZCV flag register gated by S, compare/test opcodes and Cond.
// Ports:
//   clk, rst (sync, active-high)
//   In1, In2, Opcode, Cond, SR_Bit, SR_Cont, S, Immediate
//   Out (combinational result), Flags (registered {N,Z,C,V})
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic [3:0]  Opcode,
    input  logic [3:0]  Cond,
    input  logic [4:0]  SR_Bit,
    input  logic [2:0]  SR_Cont,
    input  logic        S,
    input  logic [15:0] Immediate,
    output logic [31:0] Out,
    output logic [3:0]  Flags
);

    logic        fn, fz, fc, fv;
    logic [31:0] op2;
    logic        sc;
    logic [32:0] lsl_w;
    logic [32:0] lsr_w;
    logic [32:0] asr_w;
    logic [63:0] ror_w;
    logic [31:0] a, b, res;
    logic        cin, arith, cmp_op;
    logic [32:0] sum;
    logic        pass;
    logic        nc, nv;

    assign {fn, fz, fc, fv} = Flags;

    // Extra bit beside the operand captures the last bit shifted out.
    assign lsl_w = {1'b0, In2} << SR_Bit;
    assign lsr_w = {In2, 1'b0} >> SR_Bit;
    assign asr_w = $unsigned($signed({In2, 1'b0}) >>> SR_Bit);
    assign ror_w = {In2, In2} >> SR_Bit;

    always_comb begin
        op2 = In2;
        sc  = fc;
        unique case (SR_Cont)
            3'b000: ;
            3'b001: if (SR_Bit != 5'd0) {sc, op2} = lsl_w;
            3'b010: if (SR_Bit != 5'd0) {op2, sc} = lsr_w;
            3'b011: if (SR_Bit != 5'd0) {op2, sc} = asr_w;
            3'b100: if (SR_Bit != 5'd0) begin
                op2 = ror_w[31:0];
                sc  = ror_w[31];
            end
            3'b101: begin
                op2 = {fc, In2[31:1]};
                sc  = In2[0];
            end
            3'b110: op2 = {16'h0, Immediate};
            3'b111: op2 = {Immediate, 16'h0};
        endcase
    end

    // Every arithmetic op is a + b + cin; subtracts invert one operand.
    always_comb begin
        a     = In1;
        b     = op2;
        cin   = 1'b0;
        arith = 1'b1;
        unique case (Opcode)
            4'h2, 4'hB: begin b = ~op2; cin = 1'b1; end
            4'h3:       begin a = ~In1; cin = 1'b1; end
            4'h4, 4'hA: ;
            4'h5:       cin = fc;
            4'h6:       begin b = ~op2; cin = fc; end
            4'h7:       begin a = ~In1; cin = fc; end
            default:    arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, b} + {32'h0, cin};

    always_comb begin
        unique case (Opcode)
            4'h0, 4'h8: res = In1 & op2;
            4'h1, 4'h9: res = In1 ^ op2;
            4'hC:       res = In1 | op2;
            4'hD:       res = op2;
            4'hE:       res = In1 & ~op2;
            4'hF:       res = ~op2;
            default:    res = sum[31:0];
        endcase
    end

    always_comb begin
        unique case (Cond)
            4'h0: pass = 1'b1;
            4'h1: pass = fz;
            4'h2: pass = !fz;
            4'h3: pass = fc;
            4'h4: pass = !fc;
            4'h5: pass = fn;
            4'h6: pass = !fn;
            4'h7: pass = fv;
            4'h8: pass = !fv;
            4'h9: pass = fc && !fz;
            4'hA: pass = !fc || fz;
            4'hB: pass = fn == fv;
            4'hC: pass = fn != fv;
            4'hD: pass = !fz && (fn == fv);
            4'hE: pass = fz || (fn != fv);
            4'hF: pass = 1'b0;
        endcase
    end

    assign cmp_op = (Opcode[3:2] == 2'b10);
    assign Out    = (pass && !cmp_op) ? res : 32'h0;
    assign nc     = arith ? sum[32] : sc;
    assign nv     = arith ? ((a[31] == b[31]) && (sum[31] != a[31])) : fv;

    always_ff @(posedge clk) begin
        if (rst)
            Flags <= 4'b0000;
        else if (pass && (S || cmp_op))
            Flags <= {res[31], res == 32'h0, nc, nv};
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table then random
// stimulus against a bit-serial shifter / integer-arithmetic model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] In1, In2;
    logic [3:0]  Opcode, Cond;
    logic [4:0]  SR_Bit;
    logic [2:0]  SR_Cont;
    logic        S;
    logic [15:0] Immediate;
    logic [31:0] Out;
    logic [3:0]  Flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk(clk), .rst(rst), .In1(In1), .In2(In2), .Opcode(Opcode),
        .Cond(Cond), .SR_Bit(SR_Bit), .SR_Cont(SR_Cont), .S(S),
        .Immediate(Immediate), .Out(Out), .Flags(Flags)
    );

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [3:0]  cond;
        logic [4:0]  srb;
        logic [2:0]  src;
        logic        s;
        logic [15:0] imm;
        logic [31:0] eout;
        logic [3:0]  eflags;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [31:0] i1, input logic [31:0] i2,
                                input logic [3:0] op, input logic [3:0] cd,
                                input logic [4:0] sb, input logic [2:0] sr,
                                input logic s, input logic [15:0] im,
                                input logic [31:0] eo, input logic [3:0] ef);
        vec_t v;
        v.in1 = i1; v.in2 = i2; v.op = op; v.cond = cd; v.srb = sb;
        v.src = sr; v.s = s; v.imm = im; v.eout = eo; v.eflags = ef;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cd)
            0: return 1;       1: return z;        2: return !z;
            3: return c;       4: return !c;       5: return n;
            6: return !n;      7: return v;        8: return !v;
            9: return c && !z; 10: return !(c && !z);
            11: return n == v; 12: return n != v;
            13: return !z && n == v; 14: return !(!z && n == v);
            default: return 0;
        endcase
    endfunction

    // Reference: one-bit-at-a-time shifter, 64-bit integer arithmetic.
    task automatic model(input logic [31:0] i1, input logic [31:0] i2,
                         input logic [3:0] op, input logic [3:0] cd,
                         input logic [4:0] sb, input logic [2:0] sr,
                         input logic s, input logic [15:0] im,
                         input logic [3:0] f,
                         output logic [31:0] mout, output logic [3:0] nf);
        logic [31:0] o2, r;
        logic sc, c, nc, nv, ok, ar, cmp;
        longint u1, u2, s1, s2, full, sres, cb;
        c = f[1]; o2 = i2; sc = c;
        if (sr >= 1 && sr <= 4) begin
            for (int k = 0; k < int'(sb); k++) begin
                case (sr)
                    1: begin sc = o2[31]; o2 = o2 << 1; end
                    2: begin sc = o2[0]; o2 = o2 >> 1; end
                    3: begin sc = o2[0]; o2 = {o2[31], o2[31:1]}; end
                    default: begin sc = o2[0]; o2 = {o2[0], o2[31:1]}; end
                endcase
            end
        end else if (sr == 5) begin
            o2 = {c, i2[31:1]}; sc = i2[0];
        end else if (sr == 6) o2 = {16'h0, im};
        else if (sr == 7) o2 = {im, 16'h0};
        u1 = longint'(i1); u2 = longint'(o2);
        s1 = longint'($signed(i1)); s2 = longint'($signed(o2));
        cb = c ? 0 : 1;
        ar = 1; nc = sc; full = 0; sres = 0; r = 0;
        case (op)
            2, 11: begin full = u1 - u2; nc = u1 >= u2; sres = s1 - s2; end
            3: begin full = u2 - u1; nc = u2 >= u1; sres = s2 - s1; end
            4, 10: begin full = u1 + u2; nc = full > 64'hFFFFFFFF; sres = s1 + s2; end
            5: begin full = u1 + u2 + (1 - cb); nc = full > 64'hFFFFFFFF;
                     sres = s1 + s2 + (1 - cb); end
            6: begin full = u1 - u2 - cb; nc = u1 >= u2 + cb; sres = s1 - s2 - cb; end
            7: begin full = u2 - u1 - cb; nc = u2 >= u1 + cb; sres = s2 - s1 - cb; end
            default: ar = 0;
        endcase
        case (op)
            0, 8: r = i1 & o2;
            1, 9: r = i1 ^ o2;
            12: r = i1 | o2;
            13: r = o2;
            14: r = i1 & ~o2;
            15: r = ~o2;
            default: r = full[31:0];
        endcase
        if (ar) nv = sres > 64'sd2147483647 || sres < -64'sd2147483648;
        else begin nv = f[0]; nc = sc; end
        ok = cond_ok(cd, f);
        cmp = op >= 8 && op <= 11;
        mout = (ok && !cmp) ? r : 32'h0;
        nf = (ok && (s || cmp)) ? {r[31], r == 0, nc, nv} : f;
    endtask

    task automatic drive(input vec_t v);
        In1 = v.in1; In2 = v.in2; Opcode = v.op; Cond = v.cond;
        SR_Bit = v.srb; SR_Cont = v.src; S = v.s; Immediate = v.imm;
    endtask

    initial begin
        logic [31:0] mo;
        logic [3:0]  mf, nf;
        vec_t        rv;

        vecs[0]  = mk(15, 20, 4'hB, 0, 0, 0, 1, 0, 0, 4'b1000);
        vecs[1]  = mk(5, 5, 4'hB, 0, 0, 0, 1, 0, 0, 4'b0110);
        vecs[2]  = mk(30, 25, 4'hB, 0, 0, 0, 1, 0, 0, 4'b0010);
        vecs[3]  = mk(0, 32'h80000000, 4'hB, 0, 0, 0, 1, 0, 0, 4'b1001);
        vecs[4]  = mk(1, 2, 4'h4, 0, 4, 1, 1, 0, 33, 4'b0000);
        vecs[5]  = mk(1, 2, 4'h2, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b0000);
        vecs[6]  = mk(0, 0, 4'hD, 1, 0, 6, 1, 16'h1234, 0, 4'b0000);
        vecs[7]  = mk(0, 0, 4'hD, 0, 0, 6, 1, 16'h1234, 32'h1234, 4'b0000);
        vecs[8]  = mk(0, 0, 4'hF, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 4'b1000);
        vecs[9]  = mk(32'hFFFFFFFF, 1, 4'h4, 5, 0, 0, 1, 0, 0, 4'b0110);
        vecs[10] = mk(0, 7, 4'hD, 15, 0, 0, 1, 0, 0, 4'b0110);
        vecs[11] = mk(32'hF0, 32'h0F, 4'h8, 1, 0, 0, 0, 0, 0, 4'b0110);
        vecs[12] = mk(0, 3, 4'hD, 0, 1, 2, 1, 0, 1, 4'b0010);
        vecs[13] = mk(0, 1, 4'hD, 0, 0, 5, 1, 0, 32'h80000000, 4'b1010);
        vecs[14] = mk(0, 32'h80000000, 4'hD, 0, 4, 3, 1, 0, 32'hF8000000, 4'b1000);
        vecs[15] = mk(0, 32'hAB, 4'hD, 0, 8, 4, 1, 0, 32'hAB000000, 4'b1010);
        vecs[16] = mk(0, 0, 4'hD, 0, 0, 7, 1, 16'hABCD, 32'hABCD0000, 4'b1010);
        vecs[17] = mk(1, 1, 4'h5, 0, 0, 0, 1, 0, 3, 4'b0000);
        vecs[18] = mk(5, 3, 4'h6, 0, 0, 0, 1, 0, 1, 4'b0010);

        rst = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1 check32("reset_flags", {28'h0, Flags}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 check32($sformatf("vec%0d_out", i), Out, vecs[i].eout);
            @(posedge clk);
            #1 check32($sformatf("vec%0d_flags", i), {28'h0, Flags},
                       {28'h0, vecs[i].eflags});
        end

        mf = Flags;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rv = mk($urandom, $urandom, 4'($urandom), 4'($urandom),
                    5'($urandom), 3'($urandom), 1'($urandom),
                    16'($urandom), 0, 0);
            if ($urandom_range(0, 3) == 0) rv.in2 = 32'h80000000;
            if ($urandom_range(0, 3) == 0) rv.in1 = rv.in2;
            if ($urandom_range(0, 7) == 0) rv.srb = 0;
            drive(rv);
            rst = ($urandom_range(0, 49) == 0);
            model(rv.in1, rv.in2, rv.op, rv.cond, rv.srb, rv.src, rv.s,
                  rv.imm, mf, mo, nf);
            #1 check32($sformatf("rand%0d_out", i), Out, mo);
            mf = rst ? 4'b0000 : nf;
            @(posedge clk);
            #1 check32($sformatf("rand%0d_flags", i), {28'h0, Flags},
                       {28'h0, mf});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
